seg7_readback: RTL

Receiving end of the two-digit timer's multiplexed 7-segment output. It samples the segment lines and the digit-select line, and accepts a digit only once its pattern has been stable for a programmable number of cycles. Each accepted pattern is decoded back to BCD, and a new two-digit value is published once a complete tens-then-ones frame has been captured. It serves as the on-chip readback/self-check path for the timer display.

---
 rtl/seg7_readback.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seg7_readback.sv
// seg7_readback
//   Readback path for a multiplexed two-digit 7-segment display. The sampled
//   {digit select, segment pattern} must be stable for STABLE_CYCLES samples
//   before it is accepted as a digit. Accepted patterns are decoded back to BCD.
//   A tens-then-ones pair is then published as one frame.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   seg_in[6:0] segments a..g (bit 0 = a), active high
//   dig_in      0 = tens digit shown, 1 = ones digit shown
//   tens_o/ones_o  last published digits (BCD, 0xF = blank)
//   valid_o     sticky: at least one frame published since reset
//   update_o    one-cycle pulse when tens_o/ones_o are written
//   seg_err_o   one-cycle pulse when an undecodable pattern is accepted
//   err_cnt_o   count of seg_err_o pulses, saturating at 255
module seg7_readback #(
  parameter int STABLE_CYCLES = 4  // legal 2..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       dig_in,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       valid_o,
  output logic       update_o,
  output logic       seg_err_o,
  output logic [7:0] err_cnt_o
);

  localparam logic [3:0] RUN_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] RUN_LAST = 4'(STABLE_CYCLES - 1);

  typedef enum logic {SEEK_T, SEEK_O} state_t;

  state_t     state, state_nxt;
  logic [7:0] s_q;
  logic [7:0] samp;
  logic [3:0] run_cnt, run_nxt;
  logic       change, accept;
  logic [3:0] dec_val;
  logic       dec_ok;
  logic [3:0] pend_tens, pend_nxt;
  logic [3:0] tens_nxt, ones_nxt;
  logic       valid_nxt, upd_nxt, err_nxt;
  logic [7:0] cnt_nxt;

  // The run counter tracks the sample being registered this edge.
  // run_cnt therefore equals the length of the run that s_q belongs to.
  assign samp   = {dig_in, seg_in};
  assign change = (samp != s_q);
  // Fires only on the edge where the run reaches RUN_MAX. The counter then
  // saturates, so a longer hold never re-accepts. run_cnt == 0 cannot
  // match because RUN_LAST >= 1.
  assign accept = !change && (run_cnt == RUN_LAST);

  always_comb begin
    run_nxt = run_cnt;
    if (change || run_cnt == 4'd0) run_nxt = 4'd1;
    else if (run_cnt != RUN_MAX)   run_nxt = run_cnt + 4'd1;
  end

  // On the accept edge samp == s_q, so the decode can use the registered value.
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (s_q[6:0])
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      7'h00: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_tens;
    tens_nxt  = tens_o;
    ones_nxt  = ones_o;
    valid_nxt = valid_o;
    upd_nxt   = 1'b0;
    err_nxt   = 1'b0;
    cnt_nxt   = err_cnt_o;
    if (accept) begin
      if (!dec_ok) begin
        // Bad pattern: flag it and drop any half-captured frame.
        err_nxt   = 1'b1;
        state_nxt = SEEK_T;
        pend_nxt  = 4'h0;
        if (err_cnt_o != 8'hFF) cnt_nxt = err_cnt_o + 8'd1;
      end else begin
        case (state)
          SEEK_T: if (!s_q[7]) begin
            pend_nxt  = dec_val;
            state_nxt = SEEK_O;
          end
          SEEK_O: if (s_q[7]) begin
            tens_nxt  = pend_tens;
            ones_nxt  = dec_val;
            upd_nxt   = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = SEEK_T;
          end else begin
            pend_nxt  = dec_val;  // a newer tens digit replaces the old one
          end
          default: state_nxt = SEEK_T;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= 8'h00;
      run_cnt   <= 4'd0;
      state     <= SEEK_T;
      pend_tens <= 4'h0;
      tens_o    <= 4'h0;
      ones_o    <= 4'h0;
      valid_o   <= 1'b0;
      update_o  <= 1'b0;
      seg_err_o <= 1'b0;
      err_cnt_o <= 8'h00;
    end else begin
      s_q       <= samp;
      run_cnt   <= run_nxt;
      state     <= state_nxt;
      pend_tens <= pend_nxt;
      tens_o    <= tens_nxt;
      ones_o    <= ones_nxt;
      valid_o   <= valid_nxt;
      update_o  <= upd_nxt;
      seg_err_o <= err_nxt;
      err_cnt_o <= cnt_nxt;
    end
  end

endmodule
